// File: rtl/pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl
//
// Debug controller sitting between a host command channel and a small
// pipeline. It runs or single-steps the pipeline. On a halt or step it dumps
// the machine state as a stream of words: PC, the optional enabled-cycle
// count, then registers 0..NREGS-1. A DUMP command from IDLE produces the
// same stream without touching the pipeline.
//
// Build option:
//   DEBUG_CYCLE_COUNT_EN  defined   -> enabled-cycle counter present, the
//                                      dump carries a count word
//                                      (NREGS+2 words).
//                         undefined -> no counter, cycle_count tied to 0,
//                                      the dump is NREGS+1 words.
//
// Parameters:
//   len    datapath word width
//   NB     register-address width
//   NREGS  number of registers dumped
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   cmd_valid    host command present
//   cmd          00 RUN, 01 STEP, 10 DUMP, 11 ABORT
//   cmd_ready    command accepted on cmd_valid && cmd_ready at an edge
//   halt_wb      halt instruction reached writeback
//   pc_in        current PC from fetch
//   reg_addr     register-file debug read address
//   reg_data     combinational register-file read of reg_addr
//   pipe_en      pipeline stage enable (RUN / STEP only)
//   tx_valid     dump word valid
//   tx_data      dump word
//   tx_ready     consumer accepts word on tx_valid && tx_ready at an edge
//   halted       sticky program-halted flag, cleared only by reset
//   busy         high in any state other than IDLE
//   cycle_count  saturating count of enabled pipeline cycles
// -----------------------------------------------------------------------------
module pipeline_debug_ctrl #(
  parameter int len   = 32,
  parameter int NB    = 5,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd,
  output logic            cmd_ready,
  input  logic            halt_wb,
  input  logic [len-1:0]  pc_in,
  output logic [NB-1:0]   reg_addr,
  input  logic [len-1:0]  reg_data,
  output logic            pipe_en,
  output logic            tx_valid,
  output logic [len-1:0]  tx_data,
  input  logic            tx_ready,
  output logic            halted,
  output logic            busy,
  output logic [len-1:0]  cycle_count
);

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_DUMP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [NB-1:0] LAST_REG = NB'(NREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DUMP_PC,
    S_DUMP_CNT,
    S_DUMP_REG
  } state_t;

  state_t          state_q;
  logic            halted_q;
  logic [NB-1:0]   reg_addr_q;
  logic [len-1:0]  tx_data_q;   // PC or count snapshot taken on dump-state entry

  // All outputs are decoded from registers only; no input reaches them
  // combinationally except reg_data, which is the addressed register itself.
  assign pipe_en   = (state_q == S_RUN) || (state_q == S_STEP);
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign tx_valid  = (state_q == S_DUMP_PC) || (state_q == S_DUMP_CNT) ||
                     (state_q == S_DUMP_REG);
  assign halted    = halted_q;
  assign reg_addr  = reg_addr_q;
  // reg_addr is frozen while a word is stalled, so the register read is too.
  assign tx_data   = (state_q == S_DUMP_REG) ? reg_data : tx_data_q;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [len-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (pipe_en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

  // NOTE: state is updated with non-blocking assignments so every branch
  // sees the pre-edge values of state_q, halted_q and reg_addr_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      halted_q   <= 1'b0;
      reg_addr_q <= '0;
      tx_data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (cmd)
              // After a halt, RUN and STEP are accepted but have no effect.
              CMD_RUN:  if (!halted_q) state_q <= S_RUN;
              CMD_STEP: if (!halted_q) state_q <= S_STEP;
              CMD_DUMP: begin
                state_q   <= S_DUMP_PC;
                tx_data_q <= pc_in;
              end
              CMD_ABORT: state_q <= S_IDLE;
            endcase
          end
        end

        S_RUN: begin
          // A halt takes priority over an ABORT arriving on the same edge.
          if (halt_wb) begin
            halted_q  <= 1'b1;
            state_q   <= S_DUMP_PC;
            tx_data_q <= pc_in;
          end else if (cmd_valid && (cmd == CMD_ABORT)) begin
            state_q <= S_IDLE;
          end
        end

        S_STEP: begin
          if (halt_wb) halted_q <= 1'b1;
          state_q   <= S_DUMP_PC;
          tx_data_q <= pc_in;
        end

        S_DUMP_PC: begin
          if (tx_ready) begin
`ifdef DEBUG_CYCLE_COUNT_EN
            // Pipeline is idle here, so the count is already final.
            state_q   <= S_DUMP_CNT;
            tx_data_q <= count_q;
`else
            state_q <= S_DUMP_REG;
`endif
          end
        end

        S_DUMP_CNT: begin
          if (tx_ready) state_q <= S_DUMP_REG;
        end

        S_DUMP_REG: begin
          if (tx_ready) begin
            if (reg_addr_q == LAST_REG) begin
              state_q    <= S_IDLE;
              reg_addr_q <= '0;
            end else begin
              reg_addr_q <= reg_addr_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_debug_ctrl
//
// Self-checking bench for pipeline_debug_ctrl. It runs a command table, a set
// of directed multi-cycle sequences and randomized run/step/halt/abort
// sessions. Each dump is compared word-for-word against a list of expected
// words that the bench builds itself. The bench honours DEBUG_CYCLE_COUNT_EN
// in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_ctrl;

  localparam int LEN   = 32;
  localparam int NB    = 5;
  localparam int NREGS = 32;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int NHDR  = 2;
`else
  localparam int NHDR  = 1;
`endif

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STEP  = 2'b01;
  localparam logic [1:0] C_DUMP  = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic [1:0]      cmd;
  logic            cmd_ready;
  logic            halt_wb;
  logic [LEN-1:0]  pc_in;
  logic [NB-1:0]   reg_addr;
  logic [LEN-1:0]  reg_data;
  logic            pipe_en;
  logic            tx_valid;
  logic [LEN-1:0]  tx_data;
  logic            tx_ready;
  logic            halted;
  logic            busy;
  logic [LEN-1:0]  cycle_count;

  logic [31:0]     reg_seed;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int unsigned  model_count;
  logic [31:0]  exp_q[$];

  always #5 clk = ~clk;

  // Register file stand-in: contents derived from a per-test seed.
  function automatic logic [31:0] reg_val(input logic [31:0] seed, input int unsigned a);
    return seed ^ (a * 32'h9E37_79B1) ^ 32'h0000_0100;
  endfunction

  assign reg_data = reg_val(reg_seed, 32'(reg_addr));

  pipeline_debug_ctrl #(.len(LEN), .NB(NB), .NREGS(NREGS)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .halt_wb     (halt_wb),
    .pc_in       (pc_in),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .pipe_en     (pipe_en),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .halted      (halted),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected counter value as seen on the port for this build.
  function automatic logic [31:0] exp_cnt();
`ifdef DEBUG_CYCLE_COUNT_EN
    return (model_count > 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(model_count);
`else
    return 32'h0;
`endif
  endfunction

  // Expected dump stream: PC, optional count, then every register in order.
  task automatic build_dump(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
`ifdef DEBUG_CYCLE_COUNT_EN
    exp_q.push_back(exp_cnt());
`endif
    for (int i = 0; i < NREGS; i++) exp_q.push_back(reg_val(reg_seed, i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),        64'd0);
    check({tag, "_pipe_en"},   64'(pipe_en),     64'd0);
    check({tag, "_tx_valid"},  64'(tx_valid),    64'd0);
    check({tag, "_tx_data"},   64'(tx_data),     64'd0);
    check({tag, "_reg_addr"},  64'(reg_addr),    64'd0);
    check({tag, "_count"},     64'(cycle_count), 64'd0);
    check({tag, "_halted"},    64'(halted),      64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready),   64'd1);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    halt_wb   = 1'b0;
    tx_ready  = 1'b0;
    #2;
    check_reset_outputs("rst");
    tick();
    reset       = 1'b1;
    model_count = 0;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Drains a dump and compares it with exp_q. The consumer stalls for
  // stall_len cycles when word stall_idx is presented, optionally also
  // stalls at random, and may stop early at word abort_at (>= 0).
  task automatic run_dump(input string tag, input int stall_idx, input int stall_len,
                          input bit rnd, input int abort_at);
    int got = 0;
    int cyc = 0;
    int stall_left = stall_len;
    bit prev_stall = 1'b0;
    logic [31:0]   pd = '0;
    logic [NB-1:0] pa = '0;
    while (got < exp_q.size() && cyc < 600) begin
      if (abort_at >= 0 && got == abort_at) break;
      if (got == stall_idx && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      pc_in = $urandom;  // must not disturb the PC snapshot
      #1;
      check({tag, "_tx_valid"}, 64'(tx_valid), 64'd1);
      check({tag, "_pipe_en"},  64'(pipe_en),  64'd0);
      check({tag, "_reg_addr"}, 64'(reg_addr), 64'((got >= NHDR) ? got - NHDR : 0));
      if (prev_stall) begin
        check({tag, "_hold_data"}, 64'(tx_data),  64'(pd));
        check({tag, "_hold_addr"}, 64'(reg_addr), 64'(pa));
      end
      if (tx_ready) begin
        check($sformatf("%s_word%0d", tag, got), 64'(tx_data), 64'(exp_q[got]));
        got++;
      end
      prev_stall = !tx_ready;
      pd = tx_data;
      pa = reg_addr;
      tick();
      cyc++;
    end
    if (abort_at < 0) begin
      check({tag, "_words_done"}, 64'(got), 64'(exp_q.size()));
      tx_ready = 1'b0;
      check({tag, "_end_busy"},     64'(busy),     64'd0);
      check({tag, "_end_tx_valid"}, 64'(tx_valid), 64'd0);
      check({tag, "_end_reg_addr"}, 64'(reg_addr), 64'd0);
    end
  endtask

  typedef struct {
    bit       v;
    logic [1:0] c;
    bit       hw;
    bit       tr;
    bit       pe;
    bit       rdy;
    bit       bsy;
    bit       tv;
    bit       h;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    bit prev_pe;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = C_RUN;
    halt_wb   = 1'b0;
    tx_ready  = 1'b0;
    pc_in     = '0;
    reg_seed  = $urandom;
    model_count = 0;
    #3;
    do_reset();

    // ---- command table, applied one edge per row ---------------------------
    //            v  cmd      hw tr | pe rdy bsy tv h
    tbl[0] = '{1, C_ABORT, 1, 0,   0, 1,  0,  0, 0};  // halt_wb ignored in IDLE
    tbl[1] = '{1, C_RUN,   0, 0,   1, 1,  1,  0, 0};
    tbl[2] = '{1, C_STEP,  0, 0,   1, 1,  1,  0, 0};  // dropped in RUN
    tbl[3] = '{1, C_DUMP,  0, 0,   1, 1,  1,  0, 0};  // dropped in RUN
    tbl[4] = '{1, C_ABORT, 0, 0,   0, 1,  0,  0, 0};
    tbl[5] = '{1, C_STEP,  0, 0,   1, 0,  1,  0, 0};
    tbl[6] = '{0, C_RUN,   0, 0,   0, 0,  1,  1, 0};
    tbl[7] = '{1, C_RUN,   0, 0,   0, 0,  1,  1, 0};  // ignored while dumping
    pc_in   = 32'h8;
    prev_pe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = tbl[i].v;
      cmd       = tbl[i].c;
      halt_wb   = tbl[i].hw;
      tx_ready  = tbl[i].tr;
      tick();
      if (prev_pe) model_count++;
      prev_pe = tbl[i].pe;
      check($sformatf("tbl%0d_pipe_en", i),   64'(pipe_en),     64'(tbl[i].pe));
      check($sformatf("tbl%0d_cmd_ready", i), 64'(cmd_ready),   64'(tbl[i].rdy));
      check($sformatf("tbl%0d_busy", i),      64'(busy),        64'(tbl[i].bsy));
      check($sformatf("tbl%0d_tx_valid", i),  64'(tx_valid),    64'(tbl[i].tv));
      check($sformatf("tbl%0d_halted", i),    64'(halted),      64'(tbl[i].h));
      check($sformatf("tbl%0d_count", i),     64'(cycle_count), 64'(exp_cnt()));
    end
    cmd_valid = 1'b0;
    halt_wb   = 1'b0;
    build_dump(32'h8);
    run_dump("tbl_dump", -1, 0, 1'b0, -1);

    // ---- single STEP from reset: one enabled cycle, full dump ---------------
    do_reset();
    pc_in = 32'h8;
    send_cmd(C_STEP);
    check("step_pipe_en_on", 64'(pipe_en),   64'd1);
    check("step_cmd_ready",  64'(cmd_ready), 64'd0);
    tick();
    model_count = 1;
    check("step_pipe_en_off", 64'(pipe_en),     64'd0);
    check("step_count",       64'(cycle_count), 64'(exp_cnt()));
    build_dump(32'h8);
    run_dump("step_dump", -1, 0, 1'b0, -1);

    // ---- RUN, halt after 10 enabled cycles, dump with stall at register 1 ---
    do_reset();
    pc = $urandom;
    send_cmd(C_RUN);
    repeat (10) tick();
    pc_in   = pc;
    halt_wb = 1'b1;
    tick();
    halt_wb = 1'b0;
    model_count = 11;
    check("run_halted",   64'(halted),      64'd1);
    check("run_pipe_en",  64'(pipe_en),     64'd0);
    check("run_count",    64'(cycle_count), 64'(exp_cnt()));
    build_dump(pc);
    run_dump("halt_dump", NHDR + 1, 5, 1'b0, -1);

    // ---- halted: RUN and STEP are accepted but do nothing -------------------
    send_cmd(C_RUN);
    check("hlt_run_pipe_en", 64'(pipe_en),   64'd0);
    check("hlt_run_busy",    64'(busy),      64'd0);
    check("hlt_run_ready",   64'(cmd_ready), 64'd1);
    send_cmd(C_STEP);
    check("hlt_step_pipe_en", 64'(pipe_en), 64'd0);
    check("hlt_step_busy",    64'(busy),    64'd0);
    check("hlt_still_halted", 64'(halted),  64'd1);
    pc = $urandom;
    pc_in = pc;
    send_cmd(C_DUMP);
    build_dump(pc);
    run_dump("hlt_dump", -1, 0, 1'b1, -1);

    // ---- ABORT and halt_wb on the same edge: the halt wins ------------------
    do_reset();
    send_cmd(C_RUN);
    repeat (3) tick();
    pc = $urandom;
    pc_in     = pc;
    cmd_valid = 1'b1;
    cmd       = C_ABORT;
    halt_wb   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    halt_wb   = 1'b0;
    model_count = 4;
    check("race_halted",   64'(halted),   64'd1);
    check("race_tx_valid", 64'(tx_valid), 64'd1);
    build_dump(pc);
    run_dump("race_dump", -1, 0, 1'b1, -1);

    // ---- reset at register word 12 abandons the dump ------------------------
    do_reset();
    pc_in = 32'h44;
    send_cmd(C_STEP);
    tick();
    model_count = 1;
    build_dump(32'h44);
    run_dump("abort_dump", -1, 0, 1'b0, NHDR + 12);
    check("abort_at_reg12", 64'(reg_addr), 64'd12);
    do_reset();
    repeat (3) begin
      tick();
      check("post_rst_tx_valid", 64'(tx_valid), 64'd0);
    end
    pc_in = 32'h50;
    send_cmd(C_STEP);
    tick();
    model_count = 1;
    build_dump(32'h50);
    run_dump("post_rst_dump", -1, 0, 1'b1, -1);

    // ---- randomized sessions against the model ------------------------------
    for (int it = 0; it < 8; it++) begin
      int k;
      int n;
      do_reset();
      reg_seed = $urandom;
      k = $urandom_range(0, 2);
      for (int s = 0; s < k; s++) begin
        pc = $urandom;
        pc_in = pc;
        send_cmd(C_STEP);
        tick();
        model_count++;
        build_dump(pc);
        run_dump($sformatf("rnd%0d_step%0d", it, s), -1, 0, 1'b1, -1);
      end
      n = $urandom_range(0, 15);
      send_cmd(C_RUN);
      for (int c = 0; c < n; c++) begin
        // Non-ABORT commands are dropped while running.
        cmd_valid = $urandom_range(0, 1);
        cmd       = 2'($urandom_range(0, 2));
        tick();
      end
      cmd_valid = 1'b0;
      pc = $urandom;
      pc_in = pc;
      model_count += n + 1;
      if ($urandom_range(0, 1) == 0) begin
        cmd_valid = 1'b1;
        cmd       = C_ABORT;
        tick();
        cmd_valid = 1'b0;
        check($sformatf("rnd%0d_abort_busy", it),  64'(busy),        64'd0);
        check($sformatf("rnd%0d_abort_count", it), 64'(cycle_count), 64'(exp_cnt()));
        pc = $urandom;
        pc_in = pc;
        send_cmd(C_DUMP);
        check($sformatf("rnd%0d_dump_halted", it), 64'(halted), 64'd0);
      end else begin
        halt_wb = 1'b1;
        tick();
        halt_wb = 1'b0;
        check($sformatf("rnd%0d_halted", it), 64'(halted),      64'd1);
        check($sformatf("rnd%0d_count", it),  64'(cycle_count), 64'(exp_cnt()));
      end
      build_dump(pc);
      run_dump($sformatf("rnd%0d_dump", it), $urandom_range(0, NREGS), $urandom_range(0, 4),
               1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
